// File: rtl/secuenciador_sel_4.sv
`default_nettype none
// ----------------------------------------------------------------------------
// secuenciador_sel_4 - round-robin select/settle/valid sequencer for a 4:1 mux
// Optional handshake counter via SECUENCIADOR_CONTADOR_EN. Rev 1.0
// ----------------------------------------------------------------------------
module secuenciador_sel_4 #(
  parameter int DW = 8
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_enable,
  input  logic [3:0]    i_req,
  input  logic [DW-1:0] i_dwell,
  input  logic          i_ready,
  output logic [1:0]    o_sel,
  output logic [3:0]    o_grant,
  output logic          o_valid,
  output logic          o_busy
`ifdef SECUENCIADOR_CONTADOR_EN
  ,
  output logic [15:0]   o_cnt_tx
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARB   = 2'd1,
    HOLD  = 2'd2,
    VALID = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic [1:0]    last, last_nxt;
  logic [1:0]    sel_nxt;
  logic [3:0]    grant_nxt;
  logic          valid_nxt;
  logic [DW-1:0] cnt, cnt_nxt;
  logic          found;
  logic [1:0]    winner;
  logic [1:0]    idx;
  logic          handshake;
  logic          more_work;

  assign handshake = (state == VALID) & o_valid & i_ready;
  assign more_work = i_enable & (|i_req);
  assign o_busy    = (state != IDLE);

  // Search starts one past the last served channel and wraps ascending.
  always_comb begin
    found  = 1'b0;
    winner = last;
    idx    = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      idx = last + 2'(k);
      if (!found && i_req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    sel_nxt   = o_sel;
    grant_nxt = o_grant;
    valid_nxt = o_valid;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (more_work) state_nxt = ARB;
      end
      ARB: begin
        if (found) begin
          sel_nxt   = winner;
          grant_nxt = 4'(1) << winner;
          cnt_nxt   = i_dwell;
          state_nxt = HOLD;
        end else begin
          grant_nxt = 4'd0;
          state_nxt = IDLE;
        end
      end
      HOLD: begin
        if (cnt == '0) state_nxt = VALID;
        else           cnt_nxt   = cnt - 1'b1;
      end
      VALID: begin
        // First VALID cycle raises the strobe; the handshake is then awaited.
        if (!o_valid) begin
          valid_nxt = 1'b1;
        end else if (i_ready) begin
          valid_nxt = 1'b0;
          last_nxt  = o_sel;
          if (more_work) begin
            state_nxt = ARB;
          end else begin
            grant_nxt = 4'd0;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= IDLE;
      last    <= 2'd3;
      o_sel   <= 2'd0;
      o_grant <= 4'd0;
      o_valid <= 1'b0;
      cnt     <= '0;
    end else begin
      state   <= state_nxt;
      last    <= last_nxt;
      o_sel   <= sel_nxt;
      o_grant <= grant_nxt;
      o_valid <= valid_nxt;
      cnt     <= cnt_nxt;
    end
  end

`ifdef SECUENCIADOR_CONTADOR_EN
  logic [15:0] cnt_tx;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                            cnt_tx <= 16'd0;
    else if (handshake && cnt_tx != 16'hFFFF) cnt_tx <= cnt_tx + 16'd1;
  end

  assign o_cnt_tx = cnt_tx;
`endif

endmodule
`default_nettype wire

// File: tb/tb_secuenciador_sel_4.sv
`default_nettype none
// Testbench for secuenciador_sel_4: directed scenarios plus random traffic
// against a timestamp-based transaction model.
module tb_secuenciador_sel_4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic [3:0] req = 4'd0;
  logic [7:0] dwell = 8'd0;
  logic       ready = 1'b0;
  logic [1:0] sel;
  logic [3:0] grant;
  logic       valid;
  logic       busy;
`ifdef SECUENCIADOR_CONTADOR_EN
  logic [15:0] cnt_tx;
`endif

  int checks = 0;
  int errors = 0;

  secuenciador_sel_4 #(.DW(8)) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_enable (enable),
    .i_req    (req),
    .i_dwell  (dwell),
    .i_ready  (ready),
    .o_sel    (sel),
    .o_grant  (grant),
    .o_valid  (valid),
    .o_busy   (busy)
`ifdef SECUENCIADOR_CONTADOR_EN
    ,
    .o_cnt_tx (cnt_tx)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: phase 0 idle, 1 arbitration cycle, 2 granted transaction.
  // The strobe time is a timestamp: arbitration edge + dwell + 2.
  int m_phase, m_last, m_sel, m_grant, m_valid, m_cnt, n, valid_at;

  always @(posedge clk or negedge rst_n) begin : model
    int nn, w, c;
    if (!rst_n) begin
      m_phase <= 0; m_last <= 3; m_sel <= 0; m_grant <= 0;
      m_valid <= 0; m_cnt <= 0; n <= 0; valid_at <= 0;
    end else begin
      nn = n + 1;
      w  = -1;
      case (m_phase)
        0: if (enable && req != 4'd0) m_phase <= 1;
        1: begin
          for (int k = 1; k <= 4; k++) begin
            c = (m_last + k) % 4;
            if (w < 0 && req[c]) w = c;
          end
          if (w >= 0) begin
            m_sel    <= w;
            m_grant  <= 1 << w;
            valid_at <= nn + int'(dwell) + 2;
            m_phase  <= 2;
          end else begin
            m_grant <= 0;
            m_phase <= 0;
          end
        end
        default: begin
          if (m_valid == 1 && ready) begin
            m_last  <= m_sel;
            m_valid <= 0;
            m_cnt   <= (m_cnt < 65535) ? m_cnt + 1 : m_cnt;
            if (enable && req != 4'd0) m_phase <= 1;
            else begin
              m_phase <= 0;
              m_grant <= 0;
            end
          end else begin
            m_valid <= (nn >= valid_at) ? 1 : 0;
          end
        end
      endcase
      n <= nn;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_all();
    check_val("sel",   32'(sel),   32'(m_sel));
    check_val("grant", 32'(grant), 32'(m_grant));
    check_val("valid", 32'(valid), 32'(m_valid));
    check_val("busy",  32'(busy),  32'(m_phase != 0));
`ifdef SECUENCIADOR_CONTADOR_EN
    check_val("cnt_tx", 32'(cnt_tx), 32'(m_cnt));
`endif
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      compare_all();
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_val("rst_sel",   32'(sel),   32'd0);
    check_val("rst_grant", 32'(grant), 32'd0);
    check_val("rst_valid", 32'(valid), 32'd0);
    check_val("rst_busy",  32'(busy),  32'd0);
    rst_n = 1'b1;

    // Single requester, zero dwell, always ready.
    enable = 1'b1; req = 4'b0001; dwell = 8'd0; ready = 1'b1;
    run(14);

    // All requesting: round-robin with wrap.
    req = 4'b1111; dwell = 8'd3;
    run(50);

    // Stalled consumer keeps the strobe and select stable.
    req = 4'b0100; ready = 1'b0;
    run(25);
    ready = 1'b1;
    run(4);

    // Enable dropped mid-HOLD: transaction completes, then idle.
    enable = 1'b0; req = 4'b0000;
    run(12);
    check_val("drain_busy", 32'(busy), 32'd0);
    enable = 1'b1; req = 4'b0010; dwell = 8'd6;
    run(3);
    enable = 1'b0;
    run(15);
    check_val("en_drop_grant", 32'(grant), 32'd0);
    check_val("en_drop_busy",  32'(busy),  32'd0);

    // Asynchronous reset in a long HOLD.
    enable = 1'b1; req = 4'b1111; dwell = 8'hFF;
    run(5);
    check_val("pre_rst_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_val("async_valid", 32'(valid), 32'd0);
    check_val("async_grant", 32'(grant), 32'd0);
    check_val("async_busy",  32'(busy),  32'd0);
    compare_all();
    @(negedge clk);
    rst_n = 1'b1; dwell = 8'd2;
    run(3);
    check_val("post_rst_prio", 32'(grant), 32'b0001);
    run(10);

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      compare_all();
      enable = ($urandom_range(0, 7) != 0);
      req    = 4'($urandom);
      dwell  = 8'($urandom_range(0, 4));
      ready  = 1'($urandom_range(0, 1));
    end
    run(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
